// File: rtl/por_reset_sequencer.sv
// por_reset_sequencer: turns the async active-low POR flag into ordered, gapped per-domain reset releases
// Ports:
//   clk, rst        single clock, synchronous active-high reset
//   por_n_i         asynchronous active-low power-on-reset flag (1 = power good)
//   pll_lock_i      PLL lock indicator, synchronous to clk
//   sw_rst_req_i    single-cycle software re-sequence request
//   domain_rst_o    active-high domain resets, bit 0 released first
//   all_released_o  high only in RUN
//   lock_timeout_o  sticky flag, set when the lock wait expired
//   state_o         HOLD=0, DEBOUNCE=1, WAIT_LOCK=2, RELEASE=3, RUN=4
module por_reset_sequencer #(
    parameter int NUM_DOMAINS     = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int STAGE_GAP       = 8,
    parameter int LOCK_TIMEOUT    = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   por_n_i,
    input  logic                   pll_lock_i,
    input  logic                   sw_rst_req_i,
    output logic [NUM_DOMAINS-1:0] domain_rst_o,
    output logic                   all_released_o,
    output logic                   lock_timeout_o,
    output logic [2:0]             state_o
);
    localparam int CNT_M1  = DEBOUNCE_CYCLES > STAGE_GAP ? DEBOUNCE_CYCLES : STAGE_GAP;
    localparam int CNT_MAX = CNT_M1 > LOCK_TIMEOUT ? CNT_M1 : LOCK_TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX) + 1;
    localparam int IW      = $clog2(NUM_DOMAINS) + 1;
    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DOMAINS - 1);

    typedef enum logic [2:0] {
        HOLD      = 3'd0,
        DEBOUNCE  = 3'd1,
        WAIT_LOCK = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [NUM_DOMAINS-1:0] dom_q, dom_d;
    logic                   rel_q, rel_d;
    logic                   to_q, to_d;
    logic                   por_sync;

    assign por_sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        dom_d   = dom_q;
        rel_d   = rel_q;
        to_d    = to_q;
        if (!por_sync) begin
            state_d = HOLD;
            cnt_d   = '0;
            idx_d   = '0;
            dom_d   = '1;
            rel_d   = 1'b0;
        end else if (sw_rst_req_i && (state_q == WAIT_LOCK || state_q == RELEASE || state_q == RUN)) begin
            state_d = DEBOUNCE;
            cnt_d   = '0;
            idx_d   = '0;
            dom_d   = '1;
            rel_d   = 1'b0;
        end else begin
            case (state_q)
                HOLD: begin
                    state_d = DEBOUNCE;
                    cnt_d   = '0;
                    dom_d   = '1;
                end
                DEBOUNCE: begin
                    state_d = cnt_q == DB_LAST ? WAIT_LOCK : DEBOUNCE;
                    cnt_d   = cnt_q == DB_LAST ? '0 : cnt_q + CW'(1);
                end
                WAIT_LOCK: begin
                    if (pll_lock_i || cnt_q == LOCK_LAST) begin
                        state_d = RELEASE;
                        cnt_d   = '0;
                        idx_d   = '0;
                        to_d    = to_q | ~pll_lock_i;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                RELEASE: begin
                    if (cnt_q == GAP_LAST) begin
                        // Releases are in bit order, so a zero-filling left shift drops exactly bit idx
                        dom_d   = dom_q << 1;
                        cnt_d   = '0;
                        idx_d   = idx_q + IW'(1);
                        state_d = idx_q == IDX_LAST ? RUN : RELEASE;
                        rel_d   = idx_q == IDX_LAST;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                RUN: ;
                default: begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    idx_d   = '0;
                    dom_d   = '1;
                    rel_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HOLD;
            sync_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            dom_q   <= '1;
            rel_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[SYNC_STAGES-2:0], por_n_i};
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            dom_q   <= dom_d;
            rel_q   <= rel_d;
            to_q    <= to_d;
        end
    end

    assign domain_rst_o   = dom_q;
    assign all_released_o = rel_q;
    assign lock_timeout_o = to_q;
    assign state_o        = state_q;
endmodule

// File: tb/tb_por_reset_sequencer.sv
// tb_por_reset_sequencer: randomized and directed checks of por_reset_sequencer against a phase/timer model
module tb_por_reset_sequencer;
    localparam int ND   = 4;
    localparam int SS   = 2;
    localparam int DB   = 16;
    localparam int GAP  = 8;
    localparam int LT   = 1024;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          por_n = 1'b0;
    logic          lock = 1'b0;
    logic          sw = 1'b0;
    logic [ND-1:0] dom;
    logic          rel, to;
    logic [2:0]    st;

    int vec = 0;
    int miss = 0;

    // Model: phase number, edges spent in the phase, sticky timeout, POR delay line
    int            ph = 0;
    int            t = 0;
    bit            to_m = 1'b0;
    bit            q[SS];
    logic [ND-1:0] m_dom = '1;
    logic          m_rel = 1'b0;
    logic          m_to = 1'b0;
    logic [2:0]    m_st = 3'd0;

    por_reset_sequencer #(
        .NUM_DOMAINS(ND), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB),
        .STAGE_GAP(GAP), .LOCK_TIMEOUT(LT)
    ) dut (
        .clk(clk), .rst(rst), .por_n_i(por_n), .pll_lock_i(lock),
        .sw_rst_req_i(sw), .domain_rst_o(dom), .all_released_o(rel),
        .lock_timeout_o(to), .state_o(st)
    );

    initial forever #5 clk = ~clk;

    task automatic model_edge();
        bit ps;
        ps = q[SS-1];
        if (rst) begin
            ph = 0; t = 0; to_m = 1'b0;
            for (int i = 0; i < SS; i++) q[i] = 1'b0;
        end else begin
            if (!ps) begin
                ph = 0; t = 0;
            end else if (sw && ph >= 2) begin
                ph = 1; t = 0;
            end else if (ph == 0) begin
                ph = 1; t = 0;
            end else if (ph == 1) begin
                t++;
                if (t == DB) begin ph = 2; t = 0; end
            end else if (ph == 2) begin
                if (lock) begin
                    ph = 3; t = 0;
                end else begin
                    t++;
                    if (t == LT) begin to_m = 1'b1; ph = 3; t = 0; end
                end
            end else if (ph == 3) begin
                t++;
                if (t == ND * GAP) ph = 4;
            end
            for (int i = SS - 1; i > 0; i--) q[i] = q[i-1];
            q[0] = por_n;
        end
        m_dom = ph == 3 ? ({ND{1'b1}} << (t / GAP)) : ph == 4 ? '0 : '1;
        m_rel = ph == 4;
        m_to  = to_m;
        m_st  = 3'(ph);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic boot(input int n, input logic lk);
        rst = 1'b1; sw = 1'b0; por_n = 1'b0; lock = lk;
        step();
        rst = 1'b0; por_n = 1'b1;
        repeat (n) step();
    endtask

    task automatic test_reset();
        rst = 1'b1; por_n = 1'b1; lock = 1'b1; sw = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if ({dom, rel, to, st} !== {4'b1111, 1'b0, 1'b0, 3'd0}) begin
                miss++;
                $display("FAIL reset cyc %0d got dom=%b rel=%b to=%b st=%0d exp dom=1111 rel=0 to=0 st=0", i, dom, rel, to, st);
            end
            vec++;
        end
    endtask

    task automatic test_nominal();
        logic [2:0]    es;
        logic [ND-1:0] ed;
        boot(0, 1'b1);
        for (int e = 1; e <= 56; e++) begin
            step();
            if ({dom, rel, to, st} !== {m_dom, m_rel, m_to, m_st}) begin
                miss++;
                $display("FAIL nominal_model edge %0d got %b/%b/%b/%0d exp %b/%b/%b/%0d", e, dom, rel, to, st, m_dom, m_rel, m_to, m_st);
            end
            vec++;
            if (e == 3 || e == 19 || e == 20 || e == 52) begin
                es = e == 3 ? 3'd1 : e == 19 ? 3'd2 : e == 20 ? 3'd3 : 3'd4;
                if (st !== es) begin
                    miss++;
                    $display("FAIL nominal_state edge %0d got %0d exp %0d", e, st, es);
                end
                vec++;
            end
            if (e == 28 || e == 36 || e == 44 || e == 52) begin
                ed = e == 28 ? 4'b1110 : e == 36 ? 4'b1100 : e == 44 ? 4'b1000 : 4'b0000;
                if (dom !== ed) begin
                    miss++;
                    $display("FAIL nominal_dom edge %0d got %b exp %b", e, dom, ed);
                end
                vec++;
            end
            if (e == 51 || e == 52) begin
                if (rel !== (e == 52)) begin
                    miss++;
                    $display("FAIL nominal_rel edge %0d got %b exp %b", e, rel, e == 52);
                end
                vec++;
            end
        end
    endtask

    task automatic test_glitch();
        boot(0, 1'b1);
        for (int e = 1; e <= 70; e++) begin
            por_n = e != 11;
            step();
            if ({dom, rel, to, st} !== {m_dom, m_rel, m_to, m_st}) begin
                miss++;
                $display("FAIL glitch_model edge %0d got %b/%b/%b/%0d exp %b/%b/%b/%0d", e, dom, rel, to, st, m_dom, m_rel, m_to, m_st);
            end
            vec++;
            if (e == 13 && {dom, st} !== {4'b1111, 3'd0}) begin
                miss++;
                $display("FAIL glitch_hold edge %0d got dom=%b st=%0d exp dom=1111 st=0", e, dom, st);
            end
            if (e == 62 || e == 63) begin
                if (rel !== (e == 63)) begin
                    miss++;
                    $display("FAIL glitch_rel edge %0d got %b exp %b", e, rel, e == 63);
                end
                vec++;
            end
        end
        vec++;
    endtask

    task automatic test_por_loss();
        boot(36, 1'b1);
        if (dom !== 4'b1100) begin
            miss++;
            $display("FAIL porloss_pre got %b exp 1100", dom);
        end
        vec++;
        por_n = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            if ({dom, rel, to, st} !== {m_dom, m_rel, m_to, m_st}) begin
                miss++;
                $display("FAIL porloss_model k %0d got %b/%b/%b/%0d exp %b/%b/%b/%0d", k, dom, rel, to, st, m_dom, m_rel, m_to, m_st);
            end
            vec++;
            if (k == 2 && dom !== 4'b1100) begin
                miss++;
                $display("FAIL porloss_early k %0d got %b exp 1100", k, dom);
            end
            if (k == 3 && {dom, rel, st} !== {4'b1111, 1'b0, 3'd0}) begin
                miss++;
                $display("FAIL porloss_hold k %0d got dom=%b rel=%b st=%0d exp dom=1111 rel=0 st=0", k, dom, rel, st);
            end
        end
        vec += 2;
    endtask

    task automatic test_sw_reseq();
        boot(55, 1'b1);
        sw = 1'b1;
        step();
        sw = 1'b0;
        if ({dom, rel, st} !== {4'b1111, 1'b0, 3'd1}) begin
            miss++;
            $display("FAIL swreq_next got dom=%b rel=%b st=%0d exp dom=1111 rel=0 st=1", dom, rel, st);
        end
        vec++;
        for (int k = 1; k <= 52; k++) begin
            step();
            if ({dom, rel, to, st} !== {m_dom, m_rel, m_to, m_st}) begin
                miss++;
                $display("FAIL swreq_model k %0d got %b/%b/%b/%0d exp %b/%b/%b/%0d", k, dom, rel, to, st, m_dom, m_rel, m_to, m_st);
            end
            vec++;
            if (k == 48 || k == 49) begin
                if (rel !== (k == 49)) begin
                    miss++;
                    $display("FAIL swreq_rel k %0d got %b exp %b", k, rel, k == 49);
                end
                vec++;
            end
        end
    endtask

    task automatic test_random();
        boot(0, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            por_n = $urandom_range(0, 199) != 0;
            lock  = $urandom_range(0, 3) != 0;
            sw    = $urandom_range(0, 79) == 0;
            rst   = $urandom_range(0, 999) == 0;
            step();
            if ({dom, rel, to, st} !== {m_dom, m_rel, m_to, m_st}) begin
                miss++;
                $display("FAIL random_model cyc %0d got %b/%b/%b/%0d exp %b/%b/%b/%0d", i, dom, rel, to, st, m_dom, m_rel, m_to, m_st);
            end
            vec++;
        end
        rst = 1'b0; sw = 1'b0;
    endtask

    task automatic test_lock_timeout();
        boot(0, 1'b0);
        for (int e = 1; e <= 1080; e++) begin
            step();
            if ({dom, rel, to, st} !== {m_dom, m_rel, m_to, m_st}) begin
                miss++;
                $display("FAIL timeout_model edge %0d got %b/%b/%b/%0d exp %b/%b/%b/%0d", e, dom, rel, to, st, m_dom, m_rel, m_to, m_st);
            end
            vec++;
            if (e == 1042 && {to, st} !== {1'b0, 3'd2}) begin
                miss++;
                $display("FAIL timeout_early edge %0d got to=%b st=%0d exp to=0 st=2", e, to, st);
            end
            if (e == 1043 && {to, st} !== {1'b1, 3'd3}) begin
                miss++;
                $display("FAIL timeout_hit edge %0d got to=%b st=%0d exp to=1 st=3", e, to, st);
            end
            if (e == 1051 && dom !== 4'b1110) begin
                miss++;
                $display("FAIL timeout_rel0 edge %0d got %b exp 1110", e, dom);
            end
            if (e == 1075 && {dom, st} !== {4'b0000, 3'd4}) begin
                miss++;
                $display("FAIL timeout_run edge %0d got dom=%b st=%0d exp dom=0000 st=4", e, dom, st);
            end
        end
        vec += 4;
        por_n = 1'b0;
        repeat (4) step();
        if ({to, st} !== {1'b1, 3'd0}) begin
            miss++;
            $display("FAIL timeout_sticky got to=%b st=%0d exp to=1 st=0", to, st);
        end
        vec++;
    endtask

    task automatic test_reset_priority();
        rst = 1'b1; sw = 1'b1; lock = 1'b1;
        for (int i = 0; i < 6; i++) begin
            por_n = i[0];
            step();
            if ({dom, rel, to, st} !== {4'b1111, 1'b0, 1'b0, 3'd0}) begin
                miss++;
                $display("FAIL rstprio cyc %0d got dom=%b rel=%b to=%b st=%0d exp dom=1111 rel=0 to=0 st=0", i, dom, rel, to, st);
            end
            vec++;
        end
        rst = 1'b0; sw = 1'b0; por_n = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            step();
            if ({dom, rel, to, st} !== {m_dom, m_rel, m_to, m_st}) begin
                miss++;
                $display("FAIL rstprio_model edge %0d got %b/%b/%b/%0d exp %b/%b/%b/%0d", e, dom, rel, to, st, m_dom, m_rel, m_to, m_st);
            end
            vec++;
            if (e == 2 && st !== 3'd0) begin
                miss++;
                $display("FAIL rstprio_sync edge %0d got st=%0d exp 0", e, st);
            end
            if (e == 3 && st !== 3'd1) begin
                miss++;
                $display("FAIL rstprio_deb edge %0d got st=%0d exp 1", e, st);
            end
        end
        vec += 2;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_glitch();
        test_por_loss();
        test_sw_reseq();
        test_random();
        test_lock_timeout();
        test_reset_priority();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
